seq_restoring_divider: RTL and testbench

Multi-cycle unsigned divider for the matrix arithmetic datapath. It is the inverse companion of the combinational 4-bit adder/subtractor.
- Computes quotient and remainder by restoring shift-and-subtract, one quotient bit per clock.
- Each trial subtract uses the two's-complement A + ~B + 1 form; a set borrow bit rejects the trial.
- Matrix normalisation and averaging stages use it behind a start/done handshake.

---
 rtl/seq_restoring_divider.sv | 121 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider with a start/done handshake.
// One quotient bit is resolved per clock; a zero divisor completes at once
// with an all-ones quotient and the dividend as remainder.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, next_state;

    logic [CW-1:0]    step_cnt;
    // Partial remainder is kept in WIDTH bits: it is always below the
    // divisor, so the (WIDTH+1)-bit form only exists transiently as r_shift.
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] dvs_reg;

    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   trial;
    logic             borrow;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             accept;
    logic             last_iter;

    // Handshake decode and one shift/trial-subtract iteration.
    always_comb begin
        accept    = start && (state != CALC);
        last_iter = (state == CALC) && (step_cnt == CW'(WIDTH - 1));
        r_shift   = {r_reg, q_reg[WIDTH-1]};
        trial     = r_shift + ~{1'b0, dvs_reg} + {{WIDTH{1'b0}}, 1'b1};
        borrow    = trial[WIDTH];
        r_next    = borrow ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
        q_next    = {q_reg[WIDTH-2:0], ~borrow};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and status outputs.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    next_state = (divisor == '0) ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt    <= '0;
            r_reg       <= '0;
            q_reg       <= '0;
            dvs_reg     <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                step_cnt <= '0;
                r_reg    <= '0;
                q_reg    <= dividend;
                dvs_reg  <= divisor;
            end
        end else if (state == CALC) begin
            r_reg    <= r_next;
            q_reg    <= q_next;
            step_cnt <= step_cnt + CW'(1);
            if (last_iter) begin
                quotient    <= q_next;
                remainder   <= r_next;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider (WIDTH=4).
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One complete division from IDLE, checking latency, handshake and results.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic ez, input string tag);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();                          // accepting edge
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        if (b != '0) begin
            for (int i = 0; i < W - 1; i++) begin
                check({tag, " busy"}, 32'(busy), 32'd1);
                check({tag, " early done"}, 32'(done), 32'd0);
                step();
            end
            check({tag, " busy last"}, 32'(busy), 32'd1);
            step();
        end else begin
            check({tag, " dz busy"}, 32'(busy), 32'd0);
        end
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " busy at done"}, 32'(busy), 32'd0);
        check({tag, " quotient"}, 32'(quotient), 32'(eq));
        check({tag, " remainder"}, 32'(remainder), 32'(er));
        check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(ez));
        if (b != '0) begin
            check({tag, " invariant"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check({tag, " rem<div"}, 32'(remainder < b), 32'd1);
        end
        step();
        check({tag, " done pulse"}, 32'(done), 32'd0);
        check({tag, " q hold"}, 32'(quotient), 32'(eq));
        check({tag, " r hold"}, 32'(remainder), 32'(er));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset remainder", 32'(remainder), 32'd0);
        check("reset dz", 32'(div_by_zero), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        do_div(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, "13/4");
        do_div(4'd15, 4'd1, 4'd15, 4'd0, 1'b0, "15/1");
        do_div(4'd3, 4'd7, 4'd0, 4'd3, 1'b0, "3/7");
        do_div(4'd0, 4'd5, 4'd0, 4'd0, 1'b0, "0/5");
        do_div(4'd9, 4'd0, 4'd15, 4'd9, 1'b1, "9/0");
        do_div(4'd9, 4'd3, 4'd3, 4'd0, 1'b0, "9/3");

        // Start while busy is ignored.
        dividend = 4'd14; divisor = 4'd3; start = 1'b1;
        step();                          // edge 0
        start = 1'b0;
        step();                          // edge 1
        dividend = 4'd1; divisor = 4'd1; start = 1'b1;
        step();                          // edge 2
        start = 1'b0;
        check("ign busy", 32'(busy), 32'd1);
        step();                          // edge 3
        step();                          // edge 4
        check("ign done", 32'(done), 32'd1);
        check("ign quotient", 32'(quotient), 32'd4);
        check("ign remainder", 32'(remainder), 32'd2);
        step();
        check("ign no 2nd done", 32'(done), 32'd0);
        check("ign idle", 32'(busy), 32'd0);

        // Back-to-back: start held during the DONE cycle.
        dividend = 4'd12; divisor = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        repeat (W - 1) step();
        step();
        check("b2b done1", 32'(done), 32'd1);
        check("b2b q1", 32'(quotient), 32'd2);
        check("b2b r1", 32'(remainder), 32'd2);
        dividend = 4'd7; divisor = 4'd2; start = 1'b1;
        step();                          // accepted in DONE
        start = 1'b0;
        check("b2b busy2", 32'(busy), 32'd1);
        check("b2b done off", 32'(done), 32'd0);
        repeat (W - 1) step();
        check("b2b early", 32'(done), 32'd0);
        step();
        check("b2b done2", 32'(done), 32'd1);
        check("b2b q2", 32'(quotient), 32'd3);
        check("b2b r2", 32'(remainder), 32'd1);
        step();

        // Asynchronous reset in the middle of a division.
        dividend = 4'd11; divisor = 4'd2; start = 1'b1;
        step();                          // edge 0
        start = 1'b0;
        step();
        step();                          // edge 2
        #3 rst_n = 1'b0;
        #1;
        check("arst busy", 32'(busy), 32'd0);
        check("arst done", 32'(done), 32'd0);
        check("arst quotient", 32'(quotient), 32'd0);
        check("arst remainder", 32'(remainder), 32'd0);
        check("arst dz", 32'(div_by_zero), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (W + 1) begin
            step();
            check("arst no done", 32'(done), 32'd0);
        end
        do_div(4'd11, 4'd2, 4'd5, 4'd1, 1'b0, "11/2");

        // Exhaustive sweep against a reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                if (b == 0)
                    do_div(W'(a), W'(b), '1, W'(a), 1'b1, "sweep");
                else
                    do_div(W'(a), W'(b), W'(a / b), W'(a % b), 1'b0, "sweep");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
